// File: rtl/aes_de_core.sv
// aes_de_core: iterative AES-128 inverse cipher, one round per fetched round key
module aes_de_core #(
  parameter int NO_ROWS      = 4,
  parameter int NO_COLS      = 4,
  parameter int NO_SBOX_ROWS = 16,
  parameter int NO_SBOX_COLS = 16,
  parameter int NO_ROUNDS    = 10
) (
  input  logic                                  aes_clk,
  input  logic                                  resetn,
  input  logic                                  aes_core_en,
  input  logic                                  aes_decrypt_mode_en,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  cipher_text_i,
  input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  cipher_key_i,
  input  logic                                  key_vld_i,
  output logic                                  key_req_o,
  output logic [3:0]                            key_sel_o,
  output logic                                  plain_text_rdy_o,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]  plain_text_o
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} fsm_t;
  localparam logic [7:0] INV_SBOX [NO_SBOX_ROWS][NO_SBOX_COLS] = '{
    '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb},
    '{8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb},
    '{8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e},
    '{8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25},
    '{8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92},
    '{8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84},
    '{8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06},
    '{8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b},
    '{8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73},
    '{8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e},
    '{8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b},
    '{8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4},
    '{8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f},
    '{8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef},
    '{8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61},
    '{8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d}
  };
  fsm_t fsm;
  logic [3:0] rnd;
  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] st, ark, imc;
  function automatic logic [7:0] inv_sb(input logic [7:0] b);
    return INV_SBOX[b[7:4]][b[3:0]];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    return (k[0] ? b : 8'h00) ^ (k[1] ? xt(b) : 8'h00) ^ (k[2] ? xt(xt(b)) : 8'h00) ^ (k[3] ? xt(xt(xt(b))) : 8'h00);
  endfunction
  function automatic logic [3:0] mc(input int i);
    return i == 0 ? 4'he : i == 1 ? 4'hb : i == 2 ? 4'hd : 4'h9;
  endfunction
  // ark = InvSubBytes(InvShiftRows(st)) ^ key; imc = InvMixColumns(ark)
  for (genvar r = 0; r < NO_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NO_COLS; c++) begin : g_col
      assign ark[r][c] = inv_sb(st[r][(c + NO_COLS - r) % NO_COLS]) ^ cipher_key_i[r][c];
      assign imc[r][c] = gm(ark[0][c], mc((NO_ROWS - r) % NO_ROWS)) ^ gm(ark[1][c], mc((NO_ROWS + 1 - r) % NO_ROWS))
                       ^ gm(ark[2][c], mc((NO_ROWS + 2 - r) % NO_ROWS)) ^ gm(ark[3][c], mc((NO_ROWS + 3 - r) % NO_ROWS));
    end
  end
  // round sequencer: fetch keys 10..0, apply one round per accepted key, abort when disabled
  always_ff @(posedge aes_clk or negedge resetn)
    if (!resetn) begin
      fsm <= S_IDLE;
      rnd <= '0;
      st <= '0;
      key_req_o <= 1'b0;
      key_sel_o <= '0;
      plain_text_rdy_o <= 1'b0;
      plain_text_o <= '0;
    end else if (fsm != S_IDLE && !aes_core_en) begin
      fsm <= S_IDLE;
      key_req_o <= 1'b0;
      plain_text_rdy_o <= 1'b0;
    end else
      case (fsm)
        S_IDLE: if (aes_core_en && aes_decrypt_mode_en) begin
          st <= cipher_text_i;
          rnd <= 4'(NO_ROUNDS);
          fsm <= S_REQ;
        end
        S_REQ: begin
          key_req_o <= 1'b1;
          key_sel_o <= rnd;
          fsm <= S_WAIT;
        end
        S_WAIT: if (key_vld_i) begin
          key_req_o <= 1'b0;
          rnd <= rnd - 4'd1;
          st <= rnd == 4'(NO_ROUNDS) ? st ^ cipher_key_i : imc;
          plain_text_o <= rnd == 4'd0 ? ark : plain_text_o;
          plain_text_rdy_o <= rnd == 4'd0;
          fsm <= rnd == 4'd0 ? S_DONE : S_REQ;
        end
        S_DONE: begin
          plain_text_rdy_o <= 1'b0;
          fsm <= S_IDLE;
        end
      endcase
endmodule

// File: tb/tb_aes_de_core.sv
// tb_aes_de_core: directed checks of the AES-128 inverse-cipher core with a modelled key source
module tb_aes_de_core;
  typedef logic [3:0][3:0][7:0] st_t;
  logic aes_clk = 1'b0;
  logic resetn = 1'b1;
  logic aes_core_en = 1'b0;
  logic aes_decrypt_mode_en = 1'b0;
  logic key_vld_i = 1'b0;
  st_t cipher_text_i = '0;
  st_t cipher_key_i = '0;
  logic key_req_o, plain_text_rdy_o;
  logic [3:0] key_sel_o;
  st_t plain_text_o;
  int tests = 0;
  int fails = 0;
  int rdy_cnt = 0;
  int dly = 1;
  bit rnd_dly = 0;
  logic [7:0] sb [256];
  st_t rk [11];
  logic [3:0] sel_q [$];
  st_t fk, fct, fpt;

  always #5 aes_clk = ~aes_clk;

  aes_de_core dut (
    .aes_clk(aes_clk), .resetn(resetn), .aes_core_en(aes_core_en),
    .aes_decrypt_mode_en(aes_decrypt_mode_en), .cipher_text_i(cipher_text_i),
    .cipher_key_i(cipher_key_i), .key_vld_i(key_vld_i), .key_req_o(key_req_o),
    .key_sel_o(key_sel_o), .plain_text_rdy_o(plain_text_rdy_o), .plain_text_o(plain_text_o)
  );

  function automatic st_t mk(input logic [127:0] v);
    st_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = v[127 - 8 * (4 * r + c) -: 8];
    return s;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // forward S-box from first principles: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input st_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int c = 0; c < 4; c++) w[c] = {key[0][c], key[1][c], key[2][c], key[3][c]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) rk[k][r][c] = w[4 * k + c][31 - 8 * r -: 8];
  endtask

  function automatic st_t enc(input st_t pt);
    st_t s, t;
    s = pt ^ rk[0];
    for (int k = 1; k <= 10; k++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c + r) % 4]];
      s = t;
      if (k < 10)
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r][c] = gmul(8'h02, s[r][c]) ^ gmul(8'h03, s[(r + 1) % 4][c]) ^ s[(r + 2) % 4][c] ^ s[(r + 3) % 4][c];
      s = t ^ rk[k];
    end
    return s;
  endfunction

  // key expander model: answers each request after d cycles, records the requested indices
  initial begin : key_src
    int cnt, d;
    bit waiting;
    logic [3:0] held;
    cnt = 0; d = 0; waiting = 0; held = '0;
    forever begin
      @(negedge aes_clk);
      if (key_vld_i) key_vld_i = 1'b0;
      else if (key_req_o === 1'b1) begin
        if (!waiting) begin
          waiting = 1;
          cnt = 0;
          held = key_sel_o;
          sel_q.push_back(key_sel_o);
          d = rnd_dly ? int'($urandom_range(0, 5)) : dly;
        end else begin
          tests++;
          if (key_sel_o !== held) begin
            fails++;
            $display("FAIL key_sel_stable: got %0d want %0d", key_sel_o, held);
          end
        end
        if (cnt >= d) begin
          cipher_key_i = rk[key_sel_o];
          key_vld_i = 1'b1;
          waiting = 0;
        end else cnt++;
      end else waiting = 0;
    end
  end

  initial begin : rdy_mon
    forever begin
      @(negedge aes_clk);
      if (plain_text_rdy_o === 1'b1) rdy_cnt++;
    end
  end

  task automatic run_dec(input st_t ct, input bit keep, output int cyc, output bit to);
    sel_q.delete();
    cipher_text_i = ct;
    aes_core_en = 1'b1;
    aes_decrypt_mode_en = 1'b1;
    cyc = 0;
    to = 1;
    while (cyc < 400) begin
      @(posedge aes_clk);
      cyc++;
      @(negedge aes_clk);
      if (plain_text_rdy_o === 1'b1) begin
        to = 0;
        break;
      end
    end
    if (!keep) begin
      aes_core_en = 1'b0;
      aes_decrypt_mode_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge aes_clk);
    resetn = 1'b0;
    repeat (2) @(negedge aes_clk);
    tests += 4;
    if (key_req_o !== 1'b0) begin fails++; $display("FAIL reset_key_req: got %b want 0", key_req_o); end
    if (key_sel_o !== 4'd0) begin fails++; $display("FAIL reset_key_sel: got %0d want 0", key_sel_o); end
    if (plain_text_rdy_o !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b want 0", plain_text_rdy_o); end
    if (plain_text_o !== '0) begin fails++; $display("FAIL reset_plain: got %h want 0", plain_text_o); end
    resetn = 1'b1;
    @(negedge aes_clk);
  endtask

  task automatic test_mode_gate();
    aes_core_en = 1'b1;
    aes_decrypt_mode_en = 1'b0;
    repeat (5) @(negedge aes_clk);
    tests++;
    if (key_req_o !== 1'b0) begin fails++; $display("FAIL mode_gate: key_req got %b want 0", key_req_o); end
    aes_core_en = 1'b0;
    @(negedge aes_clk);
  endtask

  task automatic test_fips();
    int cyc, r0;
    bit to, ok;
    dly = 1;
    rnd_dly = 0;
    expand(fk);
    r0 = rdy_cnt;
    run_dec(fct, 0, cyc, to);
    tests += 2;
    if (to) begin fails++; $display("FAIL fips_timeout: no rdy within 400 cycles"); end
    if (cyc != 34) begin fails++; $display("FAIL fips_latency: got %0d want 34", cyc); end
    ok = sel_q.size() == 11;
    for (int i = 0; i < sel_q.size() && i < 11; i++) if (sel_q[i] !== 4'(10 - i)) ok = 0;
    tests++;
    if (!ok) begin fails++; $display("FAIL fips_key_sel_seq: got %0d requests starting %0d want 11 requests 10..0", sel_q.size(), sel_q.size() > 0 ? sel_q[0] : 4'd0); end
    repeat (3) @(negedge aes_clk);
    #1;
    tests += 2;
    if (plain_text_o !== fpt) begin fails++; $display("FAIL fips_plain: got %h want %h", plain_text_o, fpt); end
    if (rdy_cnt - r0 != 1) begin fails++; $display("FAIL fips_rdy_pulses: got %0d want 1", rdy_cnt - r0); end
  endtask

  task automatic test_zero_delay();
    int cyc;
    bit to;
    dly = 0;
    run_dec(fct, 0, cyc, to);
    tests += 2;
    if (to || cyc != 23) begin fails++; $display("FAIL zero_delay_latency: got %0d want 23", cyc); end
    if (plain_text_o !== fpt) begin fails++; $display("FAIL zero_delay_plain: got %h want %h", plain_text_o, fpt); end
    dly = 1;
    @(negedge aes_clk);
  endtask

  task automatic test_abort();
    int n, r0, cyc;
    bit to;
    cipher_text_i = fct;
    aes_core_en = 1'b1;
    aes_decrypt_mode_en = 1'b1;
    n = 0;
    while (!(key_req_o === 1'b1 && key_sel_o === 4'd5) && n < 200) begin
      @(negedge aes_clk);
      n++;
    end
    tests++;
    if (n >= 200) begin fails++; $display("FAIL abort_reach_round5: got no request for round 5 want one"); end
    aes_core_en = 1'b0;
    r0 = rdy_cnt;
    @(posedge aes_clk);
    @(negedge aes_clk);
    tests++;
    if (key_req_o !== 1'b0) begin fails++; $display("FAIL abort_key_req: got %b want 0", key_req_o); end
    aes_decrypt_mode_en = 1'b0;
    repeat (40) @(negedge aes_clk);
    #1;
    tests += 2;
    if (rdy_cnt != r0) begin fails++; $display("FAIL abort_rdy: got %0d pulses want 0", rdy_cnt - r0); end
    if (plain_text_o !== fpt) begin fails++; $display("FAIL abort_plain_held: got %h want %h", plain_text_o, fpt); end
    run_dec(fct, 0, cyc, to);
    tests++;
    if (to || cyc != 34 || plain_text_o !== fpt) begin fails++; $display("FAIL abort_restart: got %0d cycles %h want 34 cycles %h", cyc, plain_text_o, fpt); end
    @(negedge aes_clk);
  endtask

  task automatic test_random_delay();
    int cyc;
    bit to;
    rnd_dly = 1;
    for (int i = 0; i < 2; i++) begin
      run_dec(fct, 0, cyc, to);
      tests++;
      if (to || plain_text_o !== fpt) begin fails++; $display("FAIL random_delay_%0d: got %h want %h", i, plain_text_o, fpt); end
      @(negedge aes_clk);
    end
    rnd_dly = 0;
  endtask

  task automatic test_back_to_back();
    st_t pt2, ct2;
    int cyc;
    bit to;
    pt2 = mk(128'h00112233_44556677_8899aabb_ccddeeff);
    ct2 = enc(pt2);
    run_dec(fct, 1, cyc, to);
    tests++;
    if (to || plain_text_o !== fpt) begin fails++; $display("FAIL b2b_first: got %h want %h", plain_text_o, fpt); end
    run_dec(ct2, 0, cyc, to);
    tests += 2;
    if (to || cyc != 35) begin fails++; $display("FAIL b2b_gap: got %0d want 35", cyc); end
    if (plain_text_o !== pt2) begin fails++; $display("FAIL b2b_second: got %h want %h", plain_text_o, pt2); end
    @(negedge aes_clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    cipher_text_i = fct;
    aes_core_en = 1'b1;
    aes_decrypt_mode_en = 1'b1;
    repeat (10) @(negedge aes_clk);
    resetn = 1'b0;
    #1;
    tests += 4;
    if (key_req_o !== 1'b0) begin fails++; $display("FAIL rst_mid_key_req: got %b want 0", key_req_o); end
    if (key_sel_o !== 4'd0) begin fails++; $display("FAIL rst_mid_key_sel: got %0d want 0", key_sel_o); end
    if (plain_text_rdy_o !== 1'b0) begin fails++; $display("FAIL rst_mid_rdy: got %b want 0", plain_text_rdy_o); end
    if (plain_text_o !== '0) begin fails++; $display("FAIL rst_mid_plain: got %h want 0", plain_text_o); end
    aes_core_en = 1'b0;
    aes_decrypt_mode_en = 1'b0;
    @(negedge aes_clk);
    resetn = 1'b1;
    @(negedge aes_clk);
    run_dec(fct, 0, cyc, to);
    tests++;
    if (to || cyc != 34 || plain_text_o !== fpt) begin fails++; $display("FAIL rst_mid_rerun: got %0d cycles %h want 34 cycles %h", cyc, plain_text_o, fpt); end
    @(negedge aes_clk);
  endtask

  task automatic test_round_trip();
    st_t k, p, ct;
    int cyc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      ct = enc(p);
      @(negedge aes_clk);
      run_dec(ct, 0, cyc, to);
      tests++;
      if (to || plain_text_o !== p) begin fails++; $display("FAIL round_trip_%0d: got %h want %h", i, plain_text_o, p); end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fk  = mk(128'h2b28ab09_7eaef7cf_15d2154f_16a6883c);
    fct = mk(128'h3902dc19_25dc116a_8409850b_1dfb9732);
    fpt = mk(128'h328831e0_435a3137_f6309807_a88da234);
    build_sbox();
    expand(fk);
    test_reset();
    test_mode_gate();
    test_fips();
    test_zero_delay();
    test_abort();
    test_random_delay();
    test_back_to_back();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
